spatz_unit_dispatcher: RTL and testbench
========================================

// Module: spatz_unit_dispatcher
// PURPOSE
// - Buffered, credit-based dispatcher between spatz_controller and NrUnits execution units.
// - Generalises the fixed VFU/VLSU/VSLDU fan-out: each unit gets its own request queue and
//   response queue, and responses merge into one round-robin stream back to the controller.
// - Units may emit single-cycle response pulses with no ready; credits guarantee no response is lost.
// PARAMETERS
// - NrUnits    3   number of execution units (>=1)
// - ReqDepth   4   entries per per-unit request queue (>=1, any value)
// - RspDepth   2   entries per per-unit response queue = max issued-but-undrained reqs per unit
// - IdWidth    3   request id width
// - DataWidth  64  opaque request payload width
// PORTS
// - clk_i            in   1                      clock
// - rst_ni           in   1                      reset, synchronous, active-low
// - req_valid_i      in   1                      incoming request valid
// - req_ready_o      out  1                      incoming request ready
// - req_unit_i       in   UW=max(1,$clog2(NrUnits))  target unit index
// - req_id_i         in   IdWidth                request id
// - req_data_i       in   DataWidth              request payload
// - flush_i          in   1                      drop all queued, not-yet-issued requests
// - unit_req_valid_o out  NrUnits                per-unit issue valid
// - unit_req_ready_i in   NrUnits                per-unit issue ready
// - unit_req_id_o    out  NrUnits*IdWidth        per-unit issued id
// - unit_req_data_o  out  NrUnits*DataWidth      per-unit issued payload
// - unit_rsp_valid_i in   NrUnits                per-unit completion pulse (no ready)
// - unit_rsp_id_i    in   NrUnits*IdWidth        per-unit completion id
// - rsp_valid_o      out  1                      merged completion valid
// - rsp_ready_i      in   1                      merged completion ready
// - rsp_id_o         out  IdWidth                completion id
// - rsp_unit_o       out  UW                     unit that completed
// - busy_o           out  NrUnits                unit has queued or in-flight work
// - err_o            out  1                      one-cycle pulse: request to out-of-range unit
// BEHAVIOUR
// - Reset, sync, on the clk_i edge with rst_ni=0: all queues empty, credit[u]=RspDepth, rr_ptr=0.
//   Reset has priority over every other event, including mid-transfer. Outputs next cycle:
//   valids=0, busy_o=0, err_o=0, req_ready_o=1.
// - Accept: req_ready_o = !flush_i && (req_unit_i>=NrUnits || !reqq_full[req_unit_i]).
//   On req_valid_i&&req_ready_o, push {id,data} into reqq[req_unit_i].
//   An out-of-range unit is accepted, dropped, and err_o is pulsed the next cycle.
// - Issue: unit_req_valid_o[u] = !flush_i && !reqq_empty[u] && credit[u]!=0.
//   Payload and id come from the queue head. Handshake pops the queue and decrements credit[u].
//   Queues are not fall-through: earliest issue is 1 cycle after accept.
//   Pushing into a full queue in the same cycle as a pop is allowed.
// - Completion capture: unit_rsp_valid_i[u] pushes unit_rsp_id_i[u] into rspq[u].
//   Credits make overflow impossible; pushing into a full rspq is an assertion failure.
//   A response is visible at rsp_valid_o no earlier than the next cycle.
// - Merge: rsp_valid_o = any non-empty rspq. Grant goes to the first non-empty u starting at rr_ptr.
//   rsp_id_o/rsp_unit_o come from the granted head and stay stable while rsp_ready_i=0
//   (the grant is held until handshake). On handshake: pop, credit[u]++, rr_ptr=(u+1)%NrUnits.
// - Credit update: issue and drain on the same unit in the same cycle leave credit unchanged.
//   Credit is always in 0..RspDepth (asserted).
// - Flush: same cycle, all reqq are emptied and req_ready_o/unit_req_valid_o are forced 0.
//   In-flight requests, rspq contents and credits are untouched, so completions of issued
//   work still drain. A flush takes priority over a coincident push.
// - busy_o[u] = !reqq_empty[u] || credit[u]!=RspDepth. It clears only when that unit's
//   completions have drained.
// - Queue pointers wrap at Depth-1 (no power-of-two requirement).
//   Count width is $clog2(Depth+1), so full and empty are distinguishable.
// STRUCTURE
// - spatz_pkg gets: N_UNITS, unit_e {UNIT_VFU=0, UNIT_VLSU=1, UNIT_VSLDU=2}, dispatch_id_t.
// - Sub-module spatz_dispatch_fifo: parametrised depth/type, synchronous active-low reset,
//   flush_i, no fall-through, full/empty/usage outputs.
//   Instantiated NrUnits times for reqq and NrUnits times for rspq.
// - Credit counters, round-robin pointer/grant logic and err_o register live in this module.
// TESTING
// - Reset: drive rst_ni=0 for 1 cycle mid-traffic -> next cycle all valids 0, busy_o=0,
//   req_ready_o=1, and no stale response ever appears.
// - Single op: id 5 to unit 1 at cycle 0, ready=1 -> unit_req_valid_o[1] at cycle 1;
//   rsp pulse id 5 at cycle 3 -> rsp_valid_o at cycle 4 with id 5, unit 1;
//   busy_o[1]=0 after the handshake.
// - Credit stall (RspDepth=2): 4 reqs to unit 0, unit ready=1, instant rsp pulses, rsp_ready_i=0
//   -> exactly 2 issued. Raising rsp_ready_i -> remaining 2 issued, ids return in order 0..3.
// - Full queue (ReqDepth=4): unit_req_ready_i[2]=0, 5 back-to-back reqs to unit 2 ->
//   req_ready_o=0 on the 5th. Release ready -> 4 issued in order, then 5th accepted.
// - Round robin: rspq 0,1,2 each hold 2 entries, rsp_ready_i=1 -> rsp_unit_o sequence 0,1,2,0,1,2.
//   Stalling rsp_ready_i mid-sequence keeps the granted outputs stable.
// - Flush/error: unit 0 with 1 issued and 3 queued, pulse flush_i -> queued 3 never issued,
//   the issued op's rsp still delivered, busy_o[0] then 0. Req to unit 3 -> accepted, err_o pulse.

Source files
------------

// File: rtl/spatz_pkg.sv
// Shared definitions for the spatz unit dispatcher slice.
// Contents: default unit count, unit index enumeration, dispatch id type.
package spatz_pkg;

    localparam int unsigned N_UNITS           = 3;
    localparam int unsigned DISPATCH_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        UNIT_VFU   = 2'd0,
        UNIT_VLSU  = 2'd1,
        UNIT_VSLDU = 2'd2
    } unit_e;

    typedef logic [DISPATCH_ID_WIDTH-1:0] dispatch_id_t;

endpackage

// File: rtl/spatz_dispatch_fifo.sv
// Synchronous FIFO used for the per-unit request and response queues.
// No fall-through: data_o shows the stored head, so a pushed entry is visible
// one cycle later. Any depth >= 1; pointers wrap at Depth-1.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   flush_i             empty the queue this cycle (wins over a coincident push)
//   push_i / data_i     write side; a push into a full queue is taken only with a pop
//   pop_i / data_o      read side; data_o is the current head
//   full_o / empty_o    occupancy flags
//   usage_o             number of stored entries (0..Depth)
module spatz_dispatch_fifo #(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    output T                             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    T                    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                do_push;
    logic                do_pop;

    // Pointer increment with wrap at Depth-1 (depth need not be a power of two).
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

    // Storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spatz_unit_dispatcher.sv
// Buffered, credit-based dispatcher between the spatz controller and NrUnits
// execution units. Each unit has a request queue and a response queue; unit
// completions are single-cycle pulses with no backpressure, so issue is gated by
// a per-unit credit equal to the response queue depth. Responses merge into one
// round-robin stream whose grant is held until handshake.
// Ports:
//   clk_i, rst_ni                          clock, synchronous active-low reset
//   req_valid_i/req_ready_o                incoming request handshake
//   req_unit_i/req_id_i/req_data_i         target unit, id, payload
//   flush_i                                drop queued, not-yet-issued requests
//   unit_req_valid_o/unit_req_ready_i      per-unit issue handshake
//   unit_req_id_o/unit_req_data_o          per-unit issued id and payload
//   unit_rsp_valid_i/unit_rsp_id_i         per-unit completion pulse and id
//   rsp_valid_o/rsp_ready_i                merged completion handshake
//   rsp_id_o/rsp_unit_o                    completion id and originating unit
//   busy_o                                 unit has queued or in-flight work
//   err_o                                  pulse after a request to an out-of-range unit
module spatz_unit_dispatcher
    import spatz_pkg::*;
#(
    parameter  int unsigned NrUnits   = N_UNITS,
    parameter  int unsigned ReqDepth  = 4,
    parameter  int unsigned RspDepth  = 2,
    parameter  int unsigned IdWidth   = DISPATCH_ID_WIDTH,
    parameter  int unsigned DataWidth = 64,
    localparam int unsigned UW        = (NrUnits > 1) ? $clog2(NrUnits) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [UW-1:0]                  req_unit_i,
    input  logic [IdWidth-1:0]             req_id_i,
    input  logic [DataWidth-1:0]           req_data_i,
    input  logic                           flush_i,
    output logic [NrUnits-1:0]             unit_req_valid_o,
    input  logic [NrUnits-1:0]             unit_req_ready_i,
    output logic [NrUnits*IdWidth-1:0]     unit_req_id_o,
    output logic [NrUnits*DataWidth-1:0]   unit_req_data_o,
    input  logic [NrUnits-1:0]             unit_rsp_valid_i,
    input  logic [NrUnits*IdWidth-1:0]     unit_rsp_id_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [IdWidth-1:0]             rsp_id_o,
    output logic [UW-1:0]                  rsp_unit_o,
    output logic [NrUnits-1:0]             busy_o,
    output logic                           err_o
);

    localparam int unsigned CW  = $clog2(RspDepth + 1);
    localparam int unsigned RQW = $clog2(ReqDepth + 1);
    localparam int unsigned SQW = $clog2(RspDepth + 1);

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
    } req_t;

    req_t               req_in;
    req_t               reqq_head  [NrUnits];
    logic [RQW-1:0]     reqq_usage [NrUnits];
    logic [IdWidth-1:0] rspq_head  [NrUnits];
    logic [SQW-1:0]     rspq_usage [NrUnits];

    logic [NrUnits-1:0] reqq_full;
    logic [NrUnits-1:0] reqq_empty;
    logic [NrUnits-1:0] reqq_push;
    logic [NrUnits-1:0] issue;
    logic [NrUnits-1:0] rspq_full;
    logic [NrUnits-1:0] rspq_empty;
    logic [NrUnits-1:0] rsp_pop;

    logic               unit_ok;
    logic               sel_full;
    logic               req_fire;
    logic               rsp_fire;
    logic [UW-1:0]      grant;
    logic [UW-1:0]      scan_idx;
    logic               found;

    logic [UW-1:0]      rr_ptr_q;
    logic               lock_q;
    logic [UW-1:0]      lock_idx_q;
    logic               err_q;

    assign req_in = '{id: req_id_i, data: req_data_i};

    // Range check and full flag of the addressed queue; out-of-range units never block.
    always_comb begin
        unit_ok  = (32'(req_unit_i) < NrUnits);
        sel_full = 1'b0;
        for (int unsigned u = 0; u < NrUnits; u++) begin
            if (req_unit_i == UW'(u)) sel_full = reqq_full[u];
        end
    end

    assign req_ready_o = !flush_i && (!unit_ok || !sel_full);
    assign req_fire    = req_valid_i && req_ready_o;

    // Per-unit queues, issue gating and credit accounting.
    for (genvar u = 0; u < NrUnits; u++) begin : g_unit
        logic [CW-1:0] credit_q;

        assign reqq_push[u] = req_fire && (req_unit_i == UW'(u));

        spatz_dispatch_fifo #(
            .Depth (ReqDepth),
            .T     (req_t)
        ) i_reqq (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (reqq_push[u]),
            .data_i  (req_in),
            .pop_i   (issue[u]),
            .data_o  (reqq_head[u]),
            .full_o  (reqq_full[u]),
            .empty_o (reqq_empty[u]),
            .usage_o (reqq_usage[u])
        );

        assign unit_req_valid_o[u] = !flush_i && !reqq_empty[u] && (credit_q != '0);
        assign issue[u]            = unit_req_valid_o[u] && unit_req_ready_i[u];
        assign unit_req_id_o[u*IdWidth +: IdWidth]       = reqq_head[u].id;
        assign unit_req_data_o[u*DataWidth +: DataWidth] = reqq_head[u].data;

        spatz_dispatch_fifo #(
            .Depth (RspDepth),
            .T     (logic [IdWidth-1:0])
        ) i_rspq (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (1'b0),
            .push_i  (unit_rsp_valid_i[u]),
            .data_i  (unit_rsp_id_i[u*IdWidth +: IdWidth]),
            .pop_i   (rsp_pop[u]),
            .data_o  (rspq_head[u]),
            .full_o  (rspq_full[u]),
            .empty_o (rspq_empty[u]),
            .usage_o (rspq_usage[u])
        );

        assign rsp_pop[u] = rsp_fire && (grant == UW'(u));

        // Credit = response slots not yet claimed by an issued request.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                credit_q <= CW'(RspDepth);
            end else if (issue[u] && !rsp_pop[u]) begin
                credit_q <= credit_q - CW'(1);
            end else if (!issue[u] && rsp_pop[u]) begin
                credit_q <= credit_q + CW'(1);
            end
        end

        assign busy_o[u] = !reqq_empty[u] || (credit_q != CW'(RspDepth));

        a_rspq_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(unit_rsp_valid_i[u] && rspq_full[u]));
        a_credit_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
            credit_q <= CW'(RspDepth));
        a_rsp_slots : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (32'(rspq_usage[u]) + 32'(credit_q)) <= RspDepth);
        a_reqq_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
            32'(reqq_usage[u]) <= ReqDepth);
    end

    // Round-robin grant from rr_ptr; a stalled grant stays locked so outputs hold.
    always_comb begin
        grant    = rr_ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NrUnits; i++) begin
            scan_idx = UW'((32'(rr_ptr_q) + i) % NrUnits);
            if (!found && !rspq_empty[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
        if (lock_q) grant = lock_idx_q;
    end

    assign rsp_valid_o = !(&rspq_empty);
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;
    assign rsp_id_o    = rspq_head[grant];
    assign rsp_unit_o  = grant;
    assign err_o       = err_q;

    // Arbitration state and error pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= rsp_valid_o && !rsp_ready_i;
            lock_idx_q <= grant;
            err_q      <= req_fire && !unit_ok;
            if (rsp_fire) begin
                rr_ptr_q <= (grant == UW'(NrUnits - 1)) ? '0 : grant + UW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spatz_unit_dispatcher.sv
// Self-checking bench for spatz_unit_dispatcher (3 units, ReqDepth 4, RspDepth 2).
// Stimulus pushes expected issues/responses into scoreboard queues; a monitor
// pops and compares on every DUT handshake and also models the units' completion
// pulses (one cycle after issue, optionally held per unit).
module tb_spatz_unit_dispatcher;

    localparam int unsigned NU = 3;
    localparam int unsigned IW = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned UW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic [UW-1:0]     req_unit;
    logic [IW-1:0]     req_id;
    logic [DW-1:0]     req_data;
    logic              flush;
    logic [NU-1:0]     u_req_valid;
    logic [NU-1:0]     u_req_ready;
    logic [NU*IW-1:0]  u_req_id;
    logic [NU*DW-1:0]  u_req_data;
    logic [NU-1:0]     u_rsp_valid = '0;
    logic [NU*IW-1:0]  u_rsp_id = '0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [UW-1:0]     rsp_unit;
    logic [NU-1:0]     busy;
    logic              err;

    int                total = 0;
    int                bad = 0;
    logic [DW-1:0]     exp_issue [NU][$];
    logic [UW+IW-1:0]  exp_rsp [$];
    logic [IW-1:0]     pend [NU][$];
    logic [NU-1:0]     rsp_hold;
    int                issued_cnt [NU];
    int                rsp_cnt;
    logic [DW-1:0]     mon_e;
    logic [UW+IW-1:0]  mon_r;

    spatz_unit_dispatcher dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_unit_i       (req_unit),
        .req_id_i         (req_id),
        .req_data_i       (req_data),
        .flush_i          (flush),
        .unit_req_valid_o (u_req_valid),
        .unit_req_ready_i (u_req_ready),
        .unit_req_id_o    (u_req_id),
        .unit_req_data_o  (u_req_data),
        .unit_rsp_valid_i (u_rsp_valid),
        .unit_rsp_id_i    (u_rsp_id),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_id_o         (rsp_id),
        .rsp_unit_o       (rsp_unit),
        .busy_o           (busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int unsigned u, input logic [IW-1:0] id);
        return 64'hC0DE_0000_0000_0000 | (64'(u) << 8) | 64'(id);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    // Drive one request and hold it until accepted (bounded).
    task automatic send(input int unsigned u, input logic [IW-1:0] id);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_unit  = UW'(u);
        req_id    = id;
        req_data  = mk_data(u, id);
        #1;
        while (!req_ready && n < 64) begin
            step();
            n++;
        end
        if (!req_ready) check("send_timeout", 64'(0), 64'(1));
        else if (u < NU) exp_issue[u].push_back(mk_data(u, id));
        step();
        req_valid = 1'b0;
    endtask

    // Monitor at negedge, unit completion model at posedge+1.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            for (int unsigned u = 0; u < NU; u++) begin
                exp_issue[u].delete();
                pend[u].delete();
                issued_cnt[u] = 0;
            end
            exp_rsp.delete();
            rsp_cnt = 0;
        end else begin
            for (int unsigned u = 0; u < NU; u++) begin
                if (u_req_valid[u] && u_req_ready[u]) begin
                    issued_cnt[u]++;
                    if (exp_issue[u].size() == 0) begin
                        check("spurious_issue", 64'(u), 64'(NU));
                    end else begin
                        mon_e = exp_issue[u].pop_front();
                        check("issue_data", u_req_data[u*DW +: DW], mon_e);
                        check("issue_id", 64'(u_req_id[u*IW +: IW]), 64'(mon_e[IW-1:0]));
                    end
                    pend[u].push_back(u_req_id[u*IW +: IW]);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (exp_rsp.size() == 0) begin
                    check("spurious_rsp", 64'({rsp_unit, rsp_id}), 64'(0));
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_unit", 64'(rsp_unit), 64'(mon_r[IW +: UW]));
                    check("rsp_id", 64'(rsp_id), 64'(mon_r[IW-1:0]));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int unsigned u = 0; u < NU; u++) begin
            if (rst_n && !rsp_hold[u] && pend[u].size() > 0) begin
                u_rsp_valid[u]         = 1'b1;
                u_rsp_id[u*IW +: IW]   = pend[u].pop_front();
            end else begin
                u_rsp_valid[u] = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid   = 1'b0;
        req_unit    = '0;
        req_id      = '0;
        req_data    = '0;
        flush       = 1'b0;
        u_req_ready = '1;
        rsp_ready   = 1'b1;
        rsp_hold    = '0;
        rst_n       = 1'b0;
        steps(3);
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", 64'(u_req_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // Single op: id 5 to unit 1
        exp_rsp.push_back({2'd1, 3'd5});
        send(1, 3'd5);
        check("single_issue_valid", 64'(u_req_valid), 64'(3'b010));
        step();
        check("single_rsp_early", 64'(rsp_valid), 64'(0));
        step();
        check("single_rsp_valid", 64'(rsp_valid), 64'(1));
        check("single_rsp_id", 64'(rsp_id), 64'(5));
        check("single_rsp_unit", 64'(rsp_unit), 64'(1));
        check("single_busy_inflight", 64'(busy[1]), 64'(1));
        step();
        check("single_busy_clear", 64'(busy), 64'(0));
        check("single_drained", 64'(exp_rsp.size()), 64'(0));

        // Credit stall on unit 0
        do_reset();
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            exp_rsp.push_back({2'd0, 3'(i)});
            send(0, 3'(i));
        end
        steps(8);
        check("stall_issued", 64'(issued_cnt[0]), 64'(2));
        check("stall_busy", 64'(busy[0]), 64'(1));
        rsp_ready = 1'b1;
        steps(12);
        check("stall_issued_all", 64'(issued_cnt[0]), 64'(4));
        check("stall_rsp_cnt", 64'(rsp_cnt), 64'(4));
        check("stall_busy_clear", 64'(busy), 64'(0));

        // Full request queue on unit 2
        do_reset();
        u_req_ready = 3'b011;
        for (int unsigned i = 0; i < 4; i++) begin
            exp_rsp.push_back({2'd2, 3'(i)});
            send(2, 3'(i));
        end
        req_valid = 1'b1;
        req_unit  = 2'd2;
        req_id    = 3'd4;
        req_data  = mk_data(2, 3'd4);
        #1;
        check("full_ready_low", 64'(req_ready), 64'(0));
        check("full_no_issue", 64'(issued_cnt[2]), 64'(0));
        u_req_ready = 3'b111;
        exp_rsp.push_back({2'd2, 3'd4});
        send(2, 3'd4);
        steps(12);
        check("full_issued", 64'(issued_cnt[2]), 64'(5));
        check("full_rsp_cnt", 64'(rsp_cnt), 64'(5));

        // Round robin across three loaded response queues
        do_reset();
        rsp_ready = 1'b0;
        for (int unsigned u = 0; u < 3; u++) begin
            for (int unsigned k = 0; k < 2; k++) send(u, 3'(2 * u + k));
        end
        steps(8);
        for (int unsigned k = 0; k < 2; k++) begin
            for (int unsigned u = 0; u < 3; u++) exp_rsp.push_back({2'(u), 3'(2 * u + k)});
        end
        check("rr_first_unit", 64'(rsp_unit), 64'(0));
        rsp_ready = 1'b1;
        steps(2);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rr_hold_valid", 64'(rsp_valid), 64'(1));
            check("rr_hold_unit", 64'(rsp_unit), 64'(2));
            check("rr_hold_id", 64'(rsp_id), 64'(4));
            step();
        end
        rsp_ready = 1'b1;
        steps(6);
        check("rr_rsp_cnt", 64'(rsp_cnt), 64'(6));
        check("rr_busy_clear", 64'(busy), 64'(0));

        // Flush with one op in flight and three queued
        do_reset();
        rsp_ready   = 1'b1;
        u_req_ready = 3'b110;
        rsp_hold    = 3'b001;
        for (int unsigned i = 0; i < 4; i++) send(0, 3'(i));
        u_req_ready[0] = 1'b1;
        step();
        u_req_ready[0] = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'(0));
        check("flush_valid", 64'(u_req_valid), 64'(0));
        exp_issue[0].delete();
        step();
        flush       = 1'b0;
        u_req_ready = 3'b111;
        steps(5);
        check("flush_issued", 64'(issued_cnt[0]), 64'(1));
        check("flush_busy_inflight", 64'(busy[0]), 64'(1));
        exp_rsp.push_back({2'd0, 3'd0});
        rsp_hold = '0;
        steps(5);
        check("flush_rsp_cnt", 64'(rsp_cnt), 64'(1));
        check("flush_busy_clear", 64'(busy), 64'(0));

        // Out-of-range unit
        send(3, 3'd7);
        check("err_pulse", 64'(err), 64'(1));
        step();
        check("err_clear", 64'(err), 64'(0));
        check("err_not_busy", 64'(busy), 64'(0));

        // Reset mid-traffic
        do_reset();
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) send(i, 3'(i + 1));
        step();
        do_reset();
        check("mid_rst_valid", 64'(u_req_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        steps(10);
        check("mid_rst_rsp_cnt", 64'(rsp_cnt), 64'(0));
        check("mid_rst_quiet", 64'(rsp_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
